// File: rtl/i2c_bus_arbiter.sv
// Grants the shared byte-level I2C master engine to one of NREQ requesters and steers the DAQ/TRG/NVIO muxes.
// Define I2C_ARB_FIXED_PRI_EN for fixed priority (lowest index wins) instead of round-robin.
module i2c_bus_arbiter #(
    parameter int NREQ        = 3,
    parameter int TIMEOUT_CYC = 40000,
    parameter int HOLD_CYC    = 8
) (
    input  logic              CLK40,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [2*NREQ-1:0] REQ_BUS,
    input  logic              ENG_BUSY,
    input  logic              STAT_CLR,
    output logic [NREQ-1:0]   GNT,
    output logic [1:0]        BUS_SEL,
    output logic [2:0]        BUS_EN,
    output logic              TIMEOUT,
    output logic [7:0]        STATUS
);
    // Handshake: a requester raises REQ and holds it for the whole transaction; GNT answers one
    // cycle after selection and stays until REQ is low while ENG_BUSY is low, or the hold limit hits.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GUARD = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      bus_sel_q, bus_sel_d;
    logic [2:0]      bus_en_q, bus_en_d;
    logic            timeout_q, timeout_d;
    logic [1:0]      owner_q, owner_d;
    logic [15:0]     hold_cnt_q, hold_cnt_d, hold_inc;
    logic [7:0]      guard_cnt_q, guard_cnt_d;
    logic            to_flag_q, to_flag_d;
    logic            bad_flag_q, bad_flag_d;
    logic [NREQ-1:0] to_mask_q, to_mask_d;
    logic [NREQ-1:0] bad_mask_q, bad_mask_d;
    logic [NREQ-1:0] bad_req, eligible;
    logic            pick_valid;
    logic [1:0]      pick_idx, pick_bus, cand;
    logic            owner_req, to_event, release_now;
`ifdef I2C_ARB_FIXED_PRI_EN
    // Fixed priority keeps no rotation state.
`else
    logic [1:0]      rr_ptr_q, rr_ptr_d;
`endif

    // The current owner's bus code is frozen at grant, so its REQ_BUS is ignored while it holds GNT.
    always_comb begin
        bad_req  = '0;
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            bad_req[i]  = REQ[i] && (REQ_BUS[2*i +: 2] == 2'd3)
                          && !((state_q == ST_GRANT) && gnt_q[i]);
            eligible[i] = REQ[i] && (REQ_BUS[2*i +: 2] != 2'd3)
                          && !bad_mask_q[i] && !to_mask_q[i];
        end
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_bus   = '0;
        cand       = '0;
`ifdef I2C_ARB_FIXED_PRI_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = 2'(i);
            if (eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
                pick_bus   = REQ_BUS[{cand, 1'b0} +: 2];
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            cand = 2'((int'(rr_ptr_q) + k) % NREQ);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
                pick_bus   = REQ_BUS[{cand, 1'b0} +: 2];
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        bus_sel_d   = bus_sel_q;
        bus_en_d    = bus_en_q;
        owner_d     = owner_q;
        hold_cnt_d  = hold_cnt_q;
        guard_cnt_d = guard_cnt_q;
        timeout_d   = 1'b0;
        to_event    = 1'b0;
        release_now = 1'b0;
        hold_inc    = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : hold_cnt_q + 16'd1;
        owner_req   = |(REQ & gnt_q);
`ifdef I2C_ARB_FIXED_PRI_EN
`else
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_GRANT;
                    gnt_d      = NREQ'(1) << pick_idx;
                    owner_d    = pick_idx;
                    bus_sel_d  = pick_bus;
                    bus_en_d   = 3'b001 << pick_bus;
                    hold_cnt_d = '0;
`ifdef I2C_ARB_FIXED_PRI_EN
`else
                    rr_ptr_d   = 2'((int'(pick_idx) + 1) % NREQ);
`endif
                end
            end
            ST_GRANT: begin
                hold_cnt_d = hold_inc;
                // hold_inc counts the cycle being closed, so GNT is high for exactly TIMEOUT_CYC cycles.
                if (int'(hold_inc) >= TIMEOUT_CYC) begin
                    to_event    = 1'b1;
                    timeout_d   = 1'b1;
                    release_now = 1'b1;
                end else if (!owner_req && !ENG_BUSY) begin
                    release_now = 1'b1;
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q >= 8'(HOLD_CYC)) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (release_now) begin
            state_d     = ST_GUARD;
            gnt_d       = '0;
            bus_sel_d   = '0;
            bus_en_d    = '0;
            guard_cnt_d = '0;
        end
    end

    // Masks persist while the offending REQ stays high; a set event beats STAT_CLR.
    always_comb begin
        to_mask_d  = REQ & (to_mask_q | (to_event ? gnt_q : '0));
        bad_mask_d = REQ & (bad_mask_q | bad_req);
        to_flag_d  = to_event | (to_flag_q & ~STAT_CLR);
        bad_flag_d = (|(bad_req & ~bad_mask_q)) | (bad_flag_q & ~STAT_CLR);
    end

    always_ff @(posedge CLK40) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            bus_sel_q   <= '0;
            bus_en_q    <= '0;
            timeout_q   <= 1'b0;
            owner_q     <= '0;
            hold_cnt_q  <= '0;
            guard_cnt_q <= '0;
            to_flag_q   <= 1'b0;
            bad_flag_q  <= 1'b0;
            to_mask_q   <= '0;
            bad_mask_q  <= '0;
`ifdef I2C_ARB_FIXED_PRI_EN
`else
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            bus_sel_q   <= bus_sel_d;
            bus_en_q    <= bus_en_d;
            timeout_q   <= timeout_d;
            owner_q     <= owner_d;
            hold_cnt_q  <= hold_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            to_flag_q   <= to_flag_d;
            bad_flag_q  <= bad_flag_d;
            to_mask_q   <= to_mask_d;
            bad_mask_q  <= bad_mask_d;
`ifdef I2C_ARB_FIXED_PRI_EN
`else
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign GNT     = gnt_q;
    assign BUS_SEL = bus_sel_q;
    assign BUS_EN  = bus_en_q;
    assign TIMEOUT = timeout_q;
    assign STATUS  = {to_flag_q, bad_flag_q, state_q, owner_q, 2'b00};

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: driver pushes expected grant/release events, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;
    localparam int HOLD = 8;
    localparam int TO   = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [5:0] req_bus;
    logic       eng_busy;
    logic       stat_clr;
    logic [2:0] gnt;
    logic [1:0] bus_sel;
    logic [2:0] bus_en;
    logic       timeout;
    logic [7:0] status;

    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    logic [31:0] exp_q[$];
    logic [2:0] prev_gnt = 3'd0;
    logic [2:0] gnt2;
    int         c;

    i2c_bus_arbiter #(.NREQ(3), .TIMEOUT_CYC(TO), .HOLD_CYC(HOLD)) dut (
        .CLK40(clk), .RST(rst), .REQ(req), .REQ_BUS(req_bus), .ENG_BUSY(eng_busy),
        .STAT_CLR(stat_clr), .GNT(gnt), .BUS_SEL(bus_sel), .BUS_EN(bus_en),
        .TIMEOUT(timeout), .STATUS(status)
    );

    // clock / reset block
    always #12 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ev(input logic [1:0] kind, input logic [15:0] cy,
                                       input logic [2:0] g, input logic [1:0] bs, input logic [2:0] be,
                                       input logic to, input logic [1:0] fl, input logic [1:0] st);
        return {1'b0, kind, cy, g, bs, be, to, fl, st};
    endfunction

    function automatic logic [2:0] bus_en_of(input logic [1:0] bs);
        case (bs)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input int cy, input logic [2:0] g, input logic [1:0] bs, input logic [1:0] fl);
        exp_q.push_back(ev(2'd1, 16'(cy), g, bs, bus_en_of(bs), 1'b0, fl, 2'b01));
    endtask

    task automatic exp_release(input int cy, input logic [2:0] g, input logic to,
                               input logic [1:0] fl, input logic [1:0] st);
        exp_q.push_back(ev(2'd2, 16'(cy), g, 2'd0, 3'd0, to, fl, st));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic        gr, rel, ok;
        logic [31:0] act, e;
        gr  = (prev_gnt == 3'd0) && (gnt != 3'd0);
        rel = (prev_gnt != 3'd0) && (gnt == 3'd0);
        ok  = $onehot0(gnt) && $onehot0(bus_en)
              && ((status[5:4] == 2'b01) || (gnt == 3'd0 && bus_en == 3'd0))
              && !(timeout && !rel)
              && !(prev_gnt != 3'd0 && gnt != 3'd0 && gnt != prev_gnt);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL invariant: cyc %0d GNT %b BUS_EN %b TIMEOUT %b STATUS %b", cyc, gnt, bus_en, timeout, status);
        end
        if (gr || rel) begin
            act = ev(gr ? 2'd1 : 2'd2, 16'(cyc), gr ? gnt : prev_gnt, bus_sel, bus_en, timeout,
                     status[7:6], status[5:4]);
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event: got %08h, none expected", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    mismatched++;
                    $display("FAIL event: got %08h expected %08h", act, e);
                end
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        rst = 1'b1; req = '0; req_bus = '0; eng_busy = 1'b0; stat_clr = 1'b0;
`ifdef I2C_ARB_FIXED_PRI_EN
        gnt2 = 3'b001;
`else
        gnt2 = 3'b010;
`endif
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_bus_sel", 32'(bus_sel), 32'd0);
        check("reset_bus_en", 32'(bus_en), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        check("reset_status", 32'(status), 32'd0);

        // 1: single requester on TRG
        c = cyc; req = 3'b001; req_bus = 6'b000001;
        exp_grant(c + 1, 3'b001, 2'd1, 2'b00);
        tick(3);
        check("t1_status_state_owner", 32'(status[5:0]), 32'b010000);
        c = cyc; req = 3'b000;
        exp_release(c + 1, 3'b001, 1'b0, 2'b00, 2'b10);
        tick(HOLD + 4);
        do_reset();

        // 2: round-robin between 0 and 1, then wrap
        c = cyc; req = 3'b011; req_bus = 6'b000000;
        exp_grant(c + 1, 3'b001, 2'd0, 2'b00);
        tick(4);
        c = cyc; req = 3'b010;
        exp_release(c + 1, 3'b001, 1'b0, 2'b00, 2'b10);
        tick(2);
        req = 3'b011;
        exp_grant(c + HOLD + 3, gnt2, 2'd0, 2'b00);
        tick(HOLD + 3);
        c = cyc; req = 3'b000;
        exp_release(c + 1, gnt2, 1'b0, 2'b00, 2'b10);
        tick(HOLD + 4);
        c = cyc; req = 3'b011;
        exp_grant(c + 1, 3'b001, 2'd0, 2'b00);
        tick(3);
        c = cyc; req = 3'b000;
        exp_release(c + 1, 3'b001, 1'b0, 2'b00, 2'b10);
        tick(HOLD + 4);

        // 4: REQ drops while the engine is still busy
        c = cyc; req = 3'b010; req_bus = 6'b000000; eng_busy = 1'b1;
        exp_grant(c + 1, 3'b010, 2'd0, 2'b00);
        tick(3);
        req = 3'b000;
        tick(20);
        check("t4_gnt_held_busy", 32'(gnt), 32'b010);
        c = cyc; eng_busy = 1'b0;
        exp_release(c + 1, 3'b010, 1'b0, 2'b00, 2'b10);
        tick(HOLD + 4);

        // 3: hung owner forced off after TO cycles, then masked until REQ low
        c = cyc; req = 3'b100; req_bus = 6'b010000;
        exp_grant(c + 1, 3'b100, 2'd1, 2'b00);
        exp_release(c + TO + 1, 3'b100, 1'b1, 2'b10, 2'b10);
        tick(TO + HOLD + 10);
        check("t3_to_masked", 32'(gnt), 32'd0);
        check("t3_to_flag", 32'(status[7:6]), 32'b10);
        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
        check("t3_stat_clr", 32'(status[7:6]), 32'b00);
        req = 3'b000;
        tick(2);
        c = cyc; req = 3'b100;
        exp_grant(c + 1, 3'b100, 2'd1, 2'b00);
        tick(3);
        c = cyc; req = 3'b000;
        exp_release(c + 1, 3'b100, 1'b0, 2'b00, 2'b10);
        tick(HOLD + 4);

        // 5: invalid bus on requester 0, NVIO on requester 2; STAT_CLR collides with the set
        c = cyc; req = 3'b101; req_bus = 6'b100011; stat_clr = 1'b1;
        exp_grant(c + 1, 3'b100, 2'd2, 2'b01);
        tick(1);
        stat_clr = 1'b0;
        tick(3);
        c = cyc; req = 3'b001;
        exp_release(c + 1, 3'b100, 1'b0, 2'b01, 2'b10);
        tick(HOLD + 8);
        req_bus = 6'b100000;
        tick(5);
        check("t5_badbus_masked", 32'(gnt), 32'd0);
        check("t5_badbus_flag", 32'(status[7:6]), 32'b01);
        req = 3'b000;
        tick(2);
        c = cyc; req = 3'b001;
        exp_grant(c + 1, 3'b001, 2'd0, 2'b01);
        tick(3);
        c = cyc; req = 3'b000;
        exp_release(c + 1, 3'b001, 1'b0, 2'b01, 2'b10);
        tick(HOLD + 4);

        // 6: reset in the middle of a grant
        c = cyc; req = 3'b001; req_bus = 6'b000010;
        exp_grant(c + 1, 3'b001, 2'd2, 2'b01);
        tick(3);
        c = cyc; rst = 1'b1;
        exp_release(c + 1, 3'b001, 1'b0, 2'b00, 2'b00);
        tick(1);
        check("t6_rst_gnt", 32'(gnt), 32'd0);
        check("t6_rst_bus_en", 32'(bus_en), 32'd0);
        check("t6_rst_bus_sel", 32'(bus_sel), 32'd0);
        check("t6_rst_status", 32'(status), 32'd0);
        req = 3'b000;
        tick(1);
        rst = 1'b0;
        tick(3);

        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
